// File: rtl/pwm_capture_module.sv
// pwm_capture_module: measures period, high time and dead time of a looped-back
// complementary PWM pair, and flags shoot-through and loss of switching.
module pwm_capture_module #(
    parameter int CNT_W       = 32,
    parameter int DEAD_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwm1_in,
    input  logic              pwm2_in,
    output logic [CNT_W-1:0]  meas_duty,
    output logic [CNT_W-1:0]  meas_period,
    output logic [DEAD_W-1:0] meas_dead,
    output logic              meas_valid,
    output logic              shoot_fault,
    output logic              stall
);
    typedef enum logic {IDLE, RUN} state_t;
    // stall fires on the edge where period_cnt would reach TIMEOUT
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    state_t state, state_nxt;
    logic [SYNC_STAGES-1:0] sync1, sync2;
    logic s1, s2, s1_d, rise, dead;
    logic [CNT_W-1:0] period_cnt, duty_cnt, period_nxt, duty_nxt, meas_period_nxt, meas_duty_nxt;
    logic [DEAD_W-1:0] dead_cnt, dead_nxt, meas_dead_nxt;
    logic valid_nxt, stall_nxt;
    assign s1   = sync1[SYNC_STAGES-1];
    assign s2   = sync2[SYNC_STAGES-1];
    assign rise = s1 & ~s1_d;
    assign dead = ~s1 & ~s2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            s1_d        <= 1'b0;
            state       <= IDLE;
            period_cnt  <= '0;
            duty_cnt    <= '0;
            dead_cnt    <= '0;
            meas_period <= '0;
            meas_duty   <= '0;
            meas_dead   <= '0;
            meas_valid  <= 1'b0;
            stall       <= 1'b0;
            shoot_fault <= 1'b0;
        end else begin
            sync1       <= {sync1[SYNC_STAGES-2:0], pwm1_in};
            sync2       <= {sync2[SYNC_STAGES-2:0], pwm2_in};
            s1_d        <= s1;
            state       <= state_nxt;
            period_cnt  <= period_nxt;
            duty_cnt    <= duty_nxt;
            dead_cnt    <= dead_nxt;
            meas_period <= meas_period_nxt;
            meas_duty   <= meas_duty_nxt;
            meas_dead   <= meas_dead_nxt;
            meas_valid  <= valid_nxt;
            stall       <= stall_nxt;
            shoot_fault <= shoot_fault | (s1 & s2);
        end
    end
    always_comb begin
        state_nxt       = state;
        period_nxt      = period_cnt;
        duty_nxt        = duty_cnt;
        dead_nxt        = dead_cnt;
        meas_period_nxt = meas_period;
        meas_duty_nxt   = meas_duty;
        meas_dead_nxt   = meas_dead;
        valid_nxt       = 1'b0;
        stall_nxt       = stall;
        if (rise) begin
            // the rise cycle itself opens the new period and is a high cycle
            state_nxt  = RUN;
            period_nxt = CNT_W'(1);
            duty_nxt   = CNT_W'(1);
            dead_nxt   = '0;
            stall_nxt  = 1'b0;
            if (state == RUN) begin
                valid_nxt       = 1'b1;
                meas_period_nxt = period_cnt;
                meas_duty_nxt   = duty_cnt;
                meas_dead_nxt   = dead_cnt;
            end
        end else if (state == IDLE) begin
            period_nxt = '0;
            duty_nxt   = '0;
            dead_nxt   = '0;
        end else if (period_cnt >= LAST) begin
            state_nxt  = IDLE;
            stall_nxt  = 1'b1;
            period_nxt = '0;
            duty_nxt   = '0;
            dead_nxt   = '0;
        end else begin
            period_nxt = period_cnt + CNT_W'(1);
            duty_nxt   = duty_cnt + CNT_W'(s1);
            dead_nxt   = (dead && dead_cnt != '1) ? dead_cnt + DEAD_W'(1) : dead_cnt;
        end
    end
endmodule

// File: tb/tb_pwm_capture_module.sv
// tb_pwm_capture_module: directed checks of period/duty/dead reporting, shoot-through,
// stall/recovery, dead-time saturation and asynchronous reset.
module tb_pwm_capture_module;
    localparam int CNT_W  = 32;
    localparam int DEAD_W = 16;
    localparam int SYNC   = 2;
    localparam int TO     = 1000;
    // pin driven at period index 0 (cycle 1); valid seen at index SYNC+1 (cycle SYNC+2)
    localparam int LAT_IDX = SYNC + 1;

    logic clk = 1'b0, rst_n = 1'b0, pwm1_in = 1'b0, pwm2_in = 1'b0;
    logic [CNT_W-1:0] meas_duty, meas_period, duty2, period2;
    logic [DEAD_W-1:0] meas_dead;
    logic [3:0] dead2;
    logic meas_valid, shoot_fault, stall, valid2, shoot2, stall2;
    int errors = 0, checks = 0;
    int nvalid, vidx, vstall = 0, first;
    logic [CNT_W-1:0] rp, rd;
    logic [DEAD_W-1:0] rdead;
    logic [3:0] rdead2;

    always #5 clk = ~clk;

    pwm_capture_module #(.CNT_W(CNT_W), .DEAD_W(DEAD_W), .SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .pwm1_in(pwm1_in), .pwm2_in(pwm2_in),
        .meas_duty(meas_duty), .meas_period(meas_period), .meas_dead(meas_dead),
        .meas_valid(meas_valid), .shoot_fault(shoot_fault), .stall(stall)
    );

    pwm_capture_module #(.CNT_W(CNT_W), .DEAD_W(4), .SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut_sat (
        .clk(clk), .rst_n(rst_n), .pwm1_in(pwm1_in), .pwm2_in(pwm2_in),
        .meas_duty(duty2), .meas_period(period2), .meas_dead(dead2),
        .meas_valid(valid2), .shoot_fault(shoot2), .stall(stall2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int i);
        if (meas_valid) begin
            nvalid++;
            vidx   = i;
            rp     = meas_period;
            rd     = meas_duty;
            rdead  = meas_dead;
            rdead2 = dead2;
            if (stall) vstall++;
        end
    endtask

    task automatic run_period(input int per, input int h1, input int s2_start, input int s2_len);
        nvalid = 0;
        vidx   = -1;
        for (int i = 0; i < per; i++) begin
            @(negedge clk);
            sample(i);
            pwm1_in = (i < h1);
            pwm2_in = (i >= s2_start && i < s2_start + s2_len);
        end
    endtask

    task automatic report(input string tag, input int p, input int d, input int dd);
        chk({tag, "_nvalid"}, nvalid, 1);
        chk({tag, "_latency"}, vidx, LAT_IDX);
        chk({tag, "_period"}, rp, p);
        chk({tag, "_duty"}, rd, d);
        chk({tag, "_dead"}, rdead, dd);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_period", meas_period, 0);
        chk("rst_duty", meas_duty, 0);
        chk("rst_dead", meas_dead, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_shoot", shoot_fault, 0);
        chk("rst_stall", stall, 0);
        rst_n = 1'b1;

        run_period(100, 30, 35, 60);
        chk("first_rise_no_valid", nvalid, 0);
        for (int k = 0; k < 3; k++) begin
            run_period(100, 30, 35, 60);
            report("nominal", 100, 30, 10);
            chk("nominal_shoot", shoot_fault, 0);
        end

        run_period(200, 50, 55, 140);
        report("step_a", 100, 30, 10);
        run_period(200, 50, 55, 140);
        report("step_b", 200, 50, 10);
        run_period(200, 150, 155, 40);
        report("step_c", 200, 50, 10);
        run_period(200, 150, 155, 40);
        report("step_d", 200, 150, 10);

        // pwm2 rises 3 cycles before pwm1 falls: overlap replaces the leading dead band
        run_period(100, 30, 27, 68);
        report("shoot_a", 200, 150, 10);
        chk("shoot_set", shoot_fault, 1);
        run_period(100, 30, 35, 60);
        report("shoot_b", 100, 30, 5);
        chk("shoot_sticky_b", shoot_fault, 1);
        run_period(100, 30, 35, 60);
        report("shoot_c", 100, 30, 10);
        chk("shoot_sticky_c", shoot_fault, 1);

        run_period(100, 30, 35, 60);
        report("pre_stall", 100, 30, 10);
        nvalid = 0;
        first  = -1;
        for (int i = 100; i <= 1100; i++) begin
            @(negedge clk);
            sample(i);
            if (stall && first < 0) first = i;
        end
        chk("stall_latency", first, TO + SYNC);
        chk("stall_no_valid", nvalid, 0);
        chk("stall_hold_period", meas_period, 100);
        chk("stall_hold_duty", meas_duty, 30);
        chk("stall_hold_dead", meas_dead, 10);

        run_period(100, 40, 45, 50);
        chk("recover_no_valid", nvalid, 0);
        chk("recover_stall_clear", stall, 0);
        run_period(100, 30, 35, 60);
        report("recover", 100, 40, 10);

        run_period(100, 30, 50, 30);
        report("sat_a", 100, 30, 10);
        run_period(100, 30, 50, 30);
        report("sat_b", 100, 30, 40);
        chk("sat_b_dead4", rdead2, 15);
        run_period(100, 30, 35, 60);
        report("sat_c", 100, 30, 40);
        chk("sat_c_dead4", rdead2, 15);

        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            sample(i);
            pwm1_in = (i < 30);
            pwm2_in = (i >= 35);
        end
        @(negedge clk);
        rst_n   = 1'b0;
        pwm1_in = 1'b0;
        pwm2_in = 1'b0;
        #1;
        chk("mid_rst_period", meas_period, 0);
        chk("mid_rst_duty", meas_duty, 0);
        chk("mid_rst_dead", meas_dead, 0);
        chk("mid_rst_valid", meas_valid, 0);
        chk("mid_rst_shoot", shoot_fault, 0);
        chk("mid_rst_stall", stall, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_period(100, 30, 35, 60);
        chk("post_rst_no_valid", nvalid, 0);
        run_period(100, 30, 35, 60);
        report("post_rst", 100, 30, 10);
        chk("post_rst_shoot", shoot_fault, 0);
        chk("valid_during_stall", vstall, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
